// File: rtl/demux3_buf.sv
// 3-way stream demultiplexer: one tagged valid/ready input steered into
// three independent per-channel FIFOs, with a sticky error for illegal tags.
module demux3_buf #(
    parameter int NB             = 32,
    parameter int DEPTH          = 2,
    parameter bit ERR_ON_ILLEGAL = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [NB-1:0] in_data,
    input  logic [1:0]    in_sel,
    output logic [2:0]    out_valid,
    input  logic [2:0]    out_ready,
    output logic [NB-1:0] out_data0,
    output logic [NB-1:0] out_data1,
    output logic [NB-1:0] out_data2,
    output logic          err,
    input  logic          err_clr
);
    // Handshake: a beat moves on a channel only in a cycle where valid and
    // ready are both high at the rising edge; valid never depends on ready.

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [NB-1:0] mem [3][DEPTH];
    logic [PW-1:0] wr_ptr [3];
    logic [PW-1:0] rd_ptr [3];
    logic [CW-1:0] cnt    [3];

    logic [2:0] full;
    logic [2:0] push_ok;
    logic [2:0] pop_ok;
    logic       illegal;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            full[i]      = (cnt[i] == CW'(DEPTH));
            out_valid[i] = (cnt[i] != '0);
        end
    end

    // in_ready looks only at registered fullness, never at out_ready, so a
    // full channel refuses a push even while its head is being popped.
    always_comb begin
        case (in_sel)
            2'd0:    in_ready = !full[0];
            2'd1:    in_ready = !full[1];
            2'd2:    in_ready = !full[2];
            default: in_ready = 1'b1;
        endcase
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            push_ok[i] = in_valid && in_ready && (in_sel == 2'(i));
            pop_ok[i]  = out_valid[i] && out_ready[i];
        end
        illegal = in_valid && (in_sel == 2'd3);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                cnt[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (push_ok[i]) wr_ptr[i] <= wr_ptr[i] + PW'(1);
                if (pop_ok[i])  rd_ptr[i] <= rd_ptr[i] + PW'(1);
                case ({push_ok[i], pop_ok[i]})
                    2'b10:   cnt[i] <= cnt[i] + CW'(1);
                    2'b01:   cnt[i] <= cnt[i] - CW'(1);
                    default: cnt[i] <= cnt[i];
                endcase
            end
        end
    end

    // Payload storage is not reset; out_valid qualifies it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (push_ok[i]) mem[i][wr_ptr[i]] <= in_data;
        end
    end

    assign out_data0 = mem[0][rd_ptr[0]];
    assign out_data1 = mem[1][rd_ptr[1]];
    assign out_data2 = mem[2][rd_ptr[2]];

    // Set wins over clear when both happen in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (illegal) begin
            err <= 1'b1;
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end

    // Benches that drive illegal tags on purpose can turn this report off.
    generate
        if (ERR_ON_ILLEGAL) begin : g_illegal_chk
            a_legal_sel : assert property (@(posedge clk) disable iff (!rst_n) !illegal)
                else $error("demux3_buf: beat accepted with in_sel == 3");
        end
    endgenerate

endmodule

// File: doc/demux3_buf.md
Name: demux3_buf

Overview:
- 3-way stream demultiplexer; the routing counterpart of the 3-way select mux.
- Accepts one valid/ready input stream tagged with a 2-bit destination and steers each beat to one of three output channels.
- Each output channel has its own FIFO, so a stalled consumer does not block the other channels unless the input beat targets it.
- Used to fan a single producer (e.g. a memory/response path) out to three consumers.

Parameters:
NB, 32 (`WORD_WIDTH`), data width
DEPTH, 2, entries per channel FIFO; power of two, >= 2

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input beat valid
in_ready  output  1  input beat accepted when in_valid & in_ready
in_data  input  NB  input payload
in_sel  input  2  destination: 0/1/2 = channel 0/1/2; 3 = illegal
out_valid  output  3  per-channel head valid, bit i = channel i
out_ready  input  3  per-channel consumer ready
out_data0  output  NB  channel 0 head payload
out_data1  output  NB  channel 1 head payload
out_data2  output  NB  channel 2 head payload
err  output  1  sticky flag: a beat with in_sel == 3 was accepted
err_clr  input  1  synchronous clear of err

Behaviour:
- Reset (rst_n low, asynchronous): all FIFOs empty (count = 0, read/write pointers = 0), out_valid = 3'b000, err = 0, in_ready = 1.
- out_dataN is don't-care while out_valid[N] = 0. Storage contents need not be reset.
- Channel FIFO i:
  - count_i ranges 0..DEPTH.
  - full_i = (count_i == DEPTH).
  - out_valid[i] = (count_i != 0).
  - out_data_i = storage at rd_ptr_i.
  - Pointers are log2(DEPTH) bits and wrap naturally.
- in_ready:
  - in_sel = 0..2: in_ready = !full_sel.
  - in_sel = 3: in_ready = 1.
  - in_ready depends only on registered state and in_sel; there is no combinational path from out_ready to in_ready.
  - A full FIFO being popped in the same cycle still refuses the push.
- Push: on in_valid & in_ready with in_sel = i < 3, write in_data at wr_ptr_i, then increment wr_ptr_i. The beat is visible at out_data_i from the next cycle, so latency is 1 cycle when the FIFO was empty.
- Pop: on out_valid[i] & out_ready[i], increment rd_ptr_i.
- Simultaneous push and pop on the same channel (only possible when not full): count unchanged, both pointers advance.
- Channels are independent. Pops on several channels in one cycle are all honoured. At most one push per cycle.
- Per-channel order preservation: beats leave channel i in acceptance order. There is no ordering guarantee across channels.
- Illegal destination (in_sel = 3, in_valid = 1):
  - The beat is accepted and dropped; no FIFO is modified.
  - err is set on the next edge.
  - In simulation, raise $error.
- err:
  - Set has priority over err_clr in the same cycle.
  - Otherwise err_clr = 1 clears err on the next edge.
- in_sel and in_data are ignored when in_valid = 0.
- Reset mid-operation: all buffered beats are discarded immediately and asynchronously; out_valid drops without waiting for a clock edge.
- No count overflow or underflow under any input sequence. Pop is gated by out_valid and push by in_ready.

Test Plan:
1. Reset, then push 0xA5A5_0001 to ch1 with all out_ready = 0 → next cycle out_valid = 3'b010, out_data1 = 0xA5A5_0001; in_ready stays 1 for ch1 (count 1 < 2).
2. Fill ch0 with 0x10, 0x11 with out_ready[0] = 0 → in_ready = 0 for in_sel = 0 while in_ready = 1 for in_sel = 2. Push 0x20 to ch2 → out_data2 = 0x20 next cycle, with ch0 unaffected.
3. ch0 full; same cycle: in_valid with in_sel = 0 and out_ready[0] = 1 → pop of 0x10 occurs, push refused (in_ready = 0). Next cycle count = 1, head = 0x11, then in_ready = 1.
4. ch2 count 1; push 0x30 while popping head (out_ready[2] = 1) → count stays 1, head becomes 0x30. Run 8 back-to-back push/pop beats 0x40..0x47 to confirm pointer wrap-around and in-order delivery.
5. in_valid with in_sel = 3, data 0xDEAD → in_ready = 1, no out_valid change, err = 1 next cycle. Assert err_clr with another in_sel = 3 beat in the same cycle → err stays 1. err_clr alone → err = 0.
6. Load ch0 = 1 entry, ch1 = 2 entries, then assert rst_n = 0 between clock edges → out_valid = 0 immediately and err = 0. After release, in_ready = 1 for all destinations.
